// File: rtl/soc_timer.sv
// Memory-mapped prescaled tick timer with compare match, sticky flag and level irq.
// Optional ONESHOT control bit (CTRL bit3) is built in when SOC_TIMER_ONESHOT_EN is defined.
module soc_timer #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic [WIDTH-1:0] r_rdata;
    logic             r_run;
    logic             r_ie;
    logic             r_reload;
    logic             r_flag;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_compare;
    logic [15:0]      r_presc;

    logic             w_accept;
    logic             w_wr;
    logic             w_wr_ctrl;
    logic             w_wr_count;
    logic             w_wr_cmp;
    logic             w_wr_stat;
    logic             w_tick;
    logic             w_match;
    logic             w_oneshot;
    logic             w_stop;
    logic [WIDTH-1:0] w_rd_val;

    // Bus handshake: an access is taken on the edge where IDLE sees sel=1; ready is
    // then high for exactly the following cycle, during which sel is ignored.
    assign w_accept   = (r_state == ST_IDLE) && sel;
    assign w_wr       = w_accept && we;
    assign w_wr_ctrl  = w_wr && (addr == 2'd0);
    assign w_wr_count = w_wr && (addr == 2'd1);
    assign w_wr_cmp   = w_wr && (addr == 2'd2);
    assign w_wr_stat  = w_wr && (addr == 2'd3);

    assign w_tick  = r_run && enable && (r_presc == PRESC_LAST);
    assign w_match = (r_count == r_compare);
    assign w_stop  = w_tick && w_match && w_oneshot;

`ifdef SOC_TIMER_ONESHOT_EN
    logic r_oneshot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oneshot <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_oneshot <= wdata[3];
        end
    end

    assign w_oneshot = r_oneshot;
`else
    assign w_oneshot = 1'b0;
`endif

    always_comb begin
        w_rd_val = '0;
        case (addr)
            2'd0:    w_rd_val[3:0] = {w_oneshot, r_reload, r_ie, r_run};
            2'd1:    w_rd_val = r_count;
            2'd2:    w_rd_val = r_compare;
            default: w_rd_val[0] = r_flag;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sel) begin
                        r_state <= ST_ACK;
                        r_ready <= 1'b1;
                        r_rdata <= w_rd_val;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // A oneshot stop needs no explicit prescaler clear: the stop always lands on a
    // tick edge, where the prescaler wraps to zero anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_wr_ctrl && !wdata[0]) begin
            r_presc <= '0;
        end else if (r_run && enable) begin
            r_presc <= w_tick ? '0 : r_presc + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run    <= 1'b0;
            r_ie     <= 1'b0;
            r_reload <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_run    <= wdata[0];
            r_ie     <= wdata[1];
            r_reload <= wdata[2];
        end else if (w_stop) begin
            r_run    <= 1'b0;
        end
    end

    // Bus writes beat the tick; the match always looks at pre-edge COUNT/COMPARE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= wdata;
        end else if (w_tick) begin
            r_count <= (w_match && r_reload) ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_compare <= '1;
        end else if (w_wr_cmp) begin
            r_compare <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flag <= 1'b0;
        end else if (w_tick && w_match) begin
            r_flag <= 1'b1;
        end else if (w_wr_stat && wdata[0]) begin
            r_flag <= 1'b0;
        end
    end

    assign ready = r_ready;
    assign rdata = r_rdata;
    assign irq   = r_flag & r_ie;

endmodule

// File: tb/tb_soc_timer.sv
// Directed bench for soc_timer (PRESCALE=4): per-cycle model comparison plus literal checks.
// Honours SOC_TIMER_ONESHOT_EN the same way the design does.
module tb_soc_timer;

    localparam int W = 32;
    localparam int P = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         sel;
    logic         we;
    logic [1:0]   addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic         ready;
    logic         irq;

    int n_cmp = 0;
    int n_err = 0;

    soc_timer #(.WIDTH(W), .PRESCALE(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .ready  (ready),
        .irq    (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] m_count, m_compare, m_rdata;
    logic         m_run, m_ie, m_reload, m_oneshot, m_flag, m_ready;
    int           m_presc;
    logic         acc, wr, tick, match;

    function automatic logic [W-1:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_oneshot, m_reload, m_ie, m_run};
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return {31'd0, m_flag};
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count = '0; m_compare = '1; m_rdata = '0;
            m_run = 0; m_ie = 0; m_reload = 0; m_oneshot = 0; m_flag = 0; m_ready = 0;
            m_presc = 0;
        end else begin
            acc   = !m_ready && sel;
            wr    = acc && we;
            tick  = m_run && enable && (m_presc == P - 1);
            match = (m_count == m_compare);
            if (acc) m_rdata = model_read(addr);
            m_ready = acc;
            if (wr && addr == 2'd1) m_count = wdata;
            else if (tick) m_count = (match && m_reload) ? '0 : m_count + 1;
            if (tick && match) m_flag = 1'b1;
            else if (wr && addr == 2'd3 && wdata[0]) m_flag = 1'b0;
            if (wr && addr == 2'd2) m_compare = wdata;
            if (wr && addr == 2'd0 && !wdata[0]) m_presc = 0;
            else if (m_run && enable) m_presc = tick ? 0 : m_presc + 1;
            if (wr && addr == 2'd0) begin
                m_run = wdata[0]; m_ie = wdata[1]; m_reload = wdata[2];
`ifdef SOC_TIMER_ONESHOT_EN
                m_oneshot = wdata[3];
`endif
            end else if (tick && match && m_oneshot) begin
                m_run = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("ready", 32'(ready), 32'(m_ready));
            check("irq", 32'(irq), 32'(m_flag & m_ie));
            if (m_ready) check("rdata", rdata, m_rdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic access(input logic w, input logic [1:0] a, input logic [W-1:0] d,
                          output logic [W-1:0] q);
        int lat;
        sel = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ready && lat < 5);
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        else check("ready_latency", 32'(lat), 32'd1);
        q = rdata;
        sel = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ready_pulse", 32'(ready), 32'd0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [W-1:0] d);
        logic [W-1:0] q;
        access(1'b1, a, d, q);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [W-1:0] exp, input string name);
        logic [W-1:0] q;
        access(1'b0, a, '0, q);
        check(name, q, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        rst = 1'b0; enable = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        idle(3);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        rd_reg(2'd0, 32'h0, "rst_ctrl");
        rd_reg(2'd1, 32'h0, "rst_count");
        rd_reg(2'd2, 32'hFFFF_FFFF, "rst_compare");
        rd_reg(2'd3, 32'h0, "rst_status");

        // handshake and read-back
        wr_reg(2'd2, 32'd5);
        rd_reg(2'd2, 32'd5, "cmp_readback");

        // periodic match: COMPARE=3, CTRL=RUN|IE|RELOAD
        wr_reg(2'd2, 32'd3);
        wr_reg(2'd0, 32'd7);
        k = 0;
        while (!irq && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("irq_latency", 32'(k), 32'd15);
        rd_reg(2'd1, 32'd0, "reload_count");
        rd_reg(2'd3, 32'd1, "flag_set");
        wr_reg(2'd3, 32'd1);
        check("irq_cleared", 32'(irq), 32'd0);

        // gating with enable
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'd7);
        idle(7);
        enable = 1'b0;
        idle(20);
        rd_reg(2'd1, 32'd2, "gated_count");
        check("gated_irq", 32'(irq), 32'd0);
        enable = 1'b1;
        idle(6);
        rd_reg(2'd1, 32'd3, "resumed_count");

        // collisions on tick edges
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd2, 32'h100);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'd3);
        idle(2);
        wr_reg(2'd1, 32'h10);
        rd_reg(2'd1, 32'h10, "count_write_wins");
        wr_reg(2'd2, 32'h10);
        rd_reg(2'd3, 32'd0, "cmp_old_value");
        wr_reg(2'd2, 32'h12);
        idle(2);
        wr_reg(2'd3, 32'd1);
        rd_reg(2'd3, 32'd1, "flag_set_wins");
        check("collide_irq", 32'(irq), 32'd1);

        // wrap without match
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd2, 32'd7);
        wr_reg(2'd1, 32'hFFFF_FFFF);
        wr_reg(2'd0, 32'd1);
        idle(3);
        rd_reg(2'd1, 32'd0, "wrap_count");
        rd_reg(2'd3, 32'd0, "wrap_flag");

        // oneshot (or bit3 ignored)
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'd0);
        wr_reg(2'd3, 32'd1);
        wr_reg(2'd0, 32'hB);
        idle(40);
`ifdef SOC_TIMER_ONESHOT_EN
        rd_reg(2'd0, 32'hA, "oneshot_ctrl");
        rd_reg(2'd1, 32'd8, "oneshot_count");
`else
        rd_reg(2'd0, 32'h3, "ctrl_bit3_ignored");
`endif

        // reset in the middle of an access
        sel = 1'b1; we = 1'b0; addr = 2'd0;
        @(posedge clk);
        #1;
        check("ready_before_rst", 32'(ready), 32'd1);
        rst = 1'b0;
        #1;
        check("ready_async_rst", 32'(ready), 32'd0);
        check("irq_async_rst", 32'(irq), 32'd0);
        @(negedge clk);
        sel = 1'b0;
        rst = 1'b1;
        rd_reg(2'd0, 32'h0, "post_rst_ctrl");
        rd_reg(2'd2, 32'hFFFF_FFFF, "post_rst_compare");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/soc_timer.md
Name: soc_timer

Overview:
- Memory-mapped system tick timer for the SoC.
- Sits directly downstream of the system controller: runs on its oscillator clock and counts only while the controller's `enable` output is high.
- Provides the core with a programmable prescaled counter, a compare register, a sticky match flag and a level interrupt.
- Sequencing: the system controller releases `enable`, then this block starts timekeeping.

Parameters:
- WIDTH, 32, width of COUNT and COMPARE and of the bus data path (min 8).
- PRESCALE, 16, clock cycles per counter tick; legal range 1..65535.

Ports:
- clk  in  1  system clock, same net as the system controller clock.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- enable  in  1  system enable from the system controller; gates the prescaler and the counter.
- sel  in  1  bus access request.
- we  in  1  1 = write, 0 = read; valid while sel=1.
- addr  in  2  register index.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data; valid while ready=1.
- ready  out  1  access acknowledge, one-cycle pulse.
- irq  out  1  interrupt request, level.

Behaviour:
- Reset (rst=0, asynchronous): CTRL=0, COUNT=0, COMPARE=all-ones, FLAG=0, prescaler=0, bus FSM=IDLE, ready=0, rdata=0, irq=0. Release is taken at the next clk edge.
- Register map:
  - 0 CTRL: bit0 RUN, bit1 IE, bit2 RELOAD; other bits read 0.
  - 1 COUNT: read/write.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 FLAG, write-1-to-clear; other bits read 0.
- Bus FSM, two states, IDLE and ACK:
  - IDLE with sel=1: the access is accepted on that edge. A write commits on the same edge; rdata is captured from the pre-write register value. Next state is ACK.
  - ACK: ready=1 for exactly one cycle; sel is ignored; return to IDLE.
  - Maximum rate is one access per 2 cycles. The master holds sel/we/addr/wdata stable until ready and may present the next access in the cycle after ready.
  - Outside ACK, ready=0 and rdata holds its last value.
- Prescaler:
  - Counts 0..PRESCALE-1 while RUN=1 and enable=1.
  - tick=1 in the cycle the prescaler equals PRESCALE-1; the prescaler then wraps to 0.
  - PRESCALE=1 gives tick every cycle.
  - RUN=0 or enable=0 holds the prescaler at its current value. A write that clears RUN also zeroes the prescaler.
- Counter on a tick edge:
  - If COUNT==COMPARE: FLAG<=1, and COUNT<=0 if RELOAD=1, else COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping from all-ones to 0 silently (no flag unless COMPARE matches).
- First tick occurs PRESCALE cycles after RUN is written 1 with enable=1.
- irq = FLAG & IE, driven from registers (no combinational path from bus inputs). irq rises the cycle after the matching tick edge.
- Simultaneous events:
  - Bus write to COUNT on a tick edge: the bus value wins; the tick increment is dropped; the match check uses the old COUNT.
  - Write-1 to FLAG on the same edge a match sets FLAG: the set wins, FLAG stays 1.
  - Write to COMPARE on a tick edge: the match check uses the old COMPARE.
- enable falls mid-count: COUNT, prescaler and FLAG freeze; bus access remains fully functional.
- rst asserted mid-access: ready drops immediately and the access is lost.

Optional Feature:
- Macro: SOC_TIMER_ONESHOT_EN.
- Defined:
  - CTRL bit3 = ONESHOT, read/write, reset 0.
  - On a match tick with ONESHOT=1, RUN is cleared on the same edge and the prescaler is zeroed.
  - COUNT still follows the RELOAD rule.
  - A bus write setting RUN on that same edge wins.
- Undefined: CTRL bit3 reads 0, writes are ignored, the timer is always periodic.

Test Plan:
- Reset: rst=0 at any cycle -> ready=0, irq=0; reads return CTRL=0, COUNT=0, COMPARE=0xFFFFFFFF, STATUS=0.
- Handshake: write COMPARE=5 with sel held -> ready high exactly 1 cycle, 1 cycle after acceptance; read-back of addr 2 gives 5; back-to-back read accepted the cycle after ready.
- Periodic match (PRESCALE=4, COMPARE=3, CTRL=0b111, enable=1) -> COUNT advances every 4 cycles 0,1,2,3,0; FLAG/irq rise the cycle after the 4th tick; W1C to STATUS clears irq next cycle.
- Gating: enable=0 after 2 ticks for 20 cycles -> COUNT stays 2, irq stays 0; resumes counting when enable=1.
- Collision: write COUNT=0x10 on a tick edge -> COUNT reads 0x10, not 0x11; W1C STATUS on a match edge -> FLAG remains 1.
- Wrap and oneshot: COUNT=0xFFFFFFFF, COMPARE=7, RELOAD=0 -> COUNT becomes 0 with FLAG=0. With SOC_TIMER_ONESHOT_EN and CTRL=0b1011 -> RUN reads 0 after the match and COUNT stops at 8.
